// File: rtl/amo_rmw_unit.sv
// RV32A/RV64A atomic read-modify-write unit: sequences AMO*, LR and SC over an
// exclusive LSU port, returns the old memory value and tracks one LR reservation.
module amo_rmw_unit #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned ADDR_W   = 64,
  parameter int unsigned RSV_LOG2 = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [4:0]        req_funct5_i,
  input  logic              req_is_word_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [XLEN-1:0]   req_data_i,
  output logic              mem_rd_valid_o,
  input  logic              mem_rd_ready_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_rdata_valid_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  output logic              mem_wr_valid_o,
  input  logic              mem_wr_ready_i,
  output logic [XLEN-1:0]   mem_wdata_o,
  output logic              mem_wr_word_o,
  input  logic              snoop_valid_i,
  input  logic [ADDR_W-1:0] snoop_addr_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [XLEN-1:0]   resp_data_o,
  output logic              resp_err_o
);

  localparam logic [4:0] F_ADD  = 5'h00;
  localparam logic [4:0] F_SWAP = 5'h01;
  localparam logic [4:0] F_LR   = 5'h02;
  localparam logic [4:0] F_SC   = 5'h03;
  localparam logic [4:0] F_XOR  = 5'h04;
  localparam logic [4:0] F_OR   = 5'h08;
  localparam logic [4:0] F_AND  = 5'h0C;
  localparam logic [4:0] F_MIN  = 5'h10;
  localparam logic [4:0] F_MAX  = 5'h14;
  localparam logic [4:0] F_MINU = 5'h18;
  localparam logic [4:0] F_MAXU = 5'h1C;

  typedef enum logic [2:0] {S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [4:0]        funct5_q, funct5_d;
  logic              word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   resp_data_q, resp_data_d;
  logic              resp_err_q, resp_err_d;
  logic              rsv_valid_q, rsv_valid_d;
  logic [ADDR_W-1:0] rsv_addr_q, rsv_addr_d;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic signed [31:0] sv;
    sv = v;
    return XLEN'(sv);
  endfunction

  function automatic logic legal_f5(input logic [4:0] f);
    case (f)
      F_ADD, F_SWAP, F_LR, F_SC, F_XOR, F_OR, F_AND,
      F_MIN, F_MAX, F_MINU, F_MAXU: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

  // An RV32 build has no doubleword ops, so every request is a word op.
  logic req_word, req_misaligned, rsv_hit;
  assign req_word       = (XLEN == 32) ? 1'b1 : req_is_word_i;
  assign req_misaligned = req_word ? (|req_addr_i[1:0]) : (|req_addr_i[2:0]);
  assign rsv_hit        = rsv_valid_q && (rsv_addr_q == (req_addr_i >> RSV_LOG2));

  // Word operands are sign-extended first: signed and unsigned ordering of the
  // extended values matches 32-bit ordering, and the low word of ADD wraps correctly.
  logic [XLEN-1:0] op_a, op_b, alu_res;
  always_comb begin
    op_a    = word_q ? sext32(mem_rdata_i[31:0]) : mem_rdata_i;
    op_b    = word_q ? sext32(data_q[31:0]) : data_q;
    alu_res = op_a + op_b;
    case (funct5_q)
      F_SWAP, F_SC: alu_res = op_b;
      F_XOR:        alu_res = op_a ^ op_b;
      F_OR:         alu_res = op_a | op_b;
      F_AND:        alu_res = op_a & op_b;
      F_MIN:        alu_res = ($signed(op_a) < $signed(op_b)) ? op_a : op_b;
      F_MAX:        alu_res = ($signed(op_a) > $signed(op_b)) ? op_a : op_b;
      F_MINU:       alu_res = (op_a < op_b) ? op_a : op_b;
      F_MAXU:       alu_res = (op_a > op_b) ? op_a : op_b;
      default:      ;
    endcase
    if (word_q) alu_res = XLEN'(alu_res[31:0]);
  end

  always_comb begin
    // NOTE: every _d takes its _q value first, so no branch can leave one unassigned and infer a latch.
    state_d     = state_q;
    funct5_d    = funct5_q;
    word_d      = word_q;
    addr_d      = addr_q;
    data_d      = data_q;
    wdata_d     = wdata_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    rsv_valid_d = rsv_valid_q;
    rsv_addr_d  = rsv_addr_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          funct5_d    = req_funct5_i;
          word_d      = req_word;
          addr_d      = req_addr_i;
          data_d      = req_data_i;
          resp_data_d = '0;
          resp_err_d  = 1'b0;
          state_d     = S_RD_REQ;
          if (req_funct5_i == F_SC) rsv_valid_d = 1'b0;
          if (!legal_f5(req_funct5_i) || req_misaligned) begin
            resp_err_d = 1'b1;
            state_d    = S_RESP;
          end else if (req_funct5_i == F_SC && !rsv_hit) begin
            resp_data_d = XLEN'(1);
            state_d     = S_RESP;
          end
        end
      end
      S_RD_REQ: if (mem_rd_ready_i) state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (mem_rdata_valid_i) begin
          resp_data_d = op_a;
          wdata_d     = alu_res;
          state_d     = S_WR_REQ;
          if (funct5_q == F_LR) begin
            rsv_valid_d = 1'b1;
            rsv_addr_d  = addr_q >> RSV_LOG2;
            state_d     = S_RESP;
          end else if (funct5_q == F_SC) begin
            resp_data_d = '0;
          end
        end
      end
      S_WR_REQ: if (mem_wr_ready_i) state_d = S_RESP;
      S_RESP:   if (resp_ready_i) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Comparing against rsv_addr_d lets a snoop also kill a reservation being set this cycle.
    if (snoop_valid_i && ((snoop_addr_i >> RSV_LOG2) == rsv_addr_d)) rsv_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      funct5_q    <= '0;
      word_q      <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      wdata_q     <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
      rsv_valid_q <= 1'b0;
      rsv_addr_q  <= '0;
    end else begin
      // NOTE: non-blocking so every flop updates from pre-edge values regardless of statement order.
      state_q     <= state_d;
      funct5_q    <= funct5_d;
      word_q      <= word_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      wdata_q     <= wdata_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
      rsv_valid_q <= rsv_valid_d;
      rsv_addr_q  <= rsv_addr_d;
    end
  end

  assign req_ready_o    = (state_q == S_IDLE);
  assign mem_rd_valid_o = (state_q == S_RD_REQ);
  assign mem_wr_valid_o = (state_q == S_WR_REQ);
  assign resp_valid_o   = (state_q == S_RESP);
  assign mem_addr_o     = addr_q;
  assign mem_wdata_o    = wdata_q;
  assign mem_wr_word_o  = word_q;
  assign resp_data_o    = resp_data_q;
  assign resp_err_o     = resp_err_q;

endmodule

// File: tb/tb_amo_rmw_unit.sv
// Directed bench for amo_rmw_unit: a small in-bench memory responder drives each op
// and the results are compared with hand-computed values.
module tb_amo_rmw_unit;

  localparam logic [4:0] F_ADD  = 5'h00;
  localparam logic [4:0] F_SWAP = 5'h01;
  localparam logic [4:0] F_LR   = 5'h02;
  localparam logic [4:0] F_SC   = 5'h03;
  localparam logic [4:0] F_XOR  = 5'h04;
  localparam logic [4:0] F_OR   = 5'h08;
  localparam logic [4:0] F_MIN  = 5'h10;
  localparam logic [4:0] F_MAX  = 5'h14;
  localparam logic [4:0] F_MAXU = 5'h1C;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [4:0]  req_funct5_i;
  logic        req_is_word_i;
  logic [63:0] req_addr_i;
  logic [63:0] req_data_i;
  logic        mem_rd_valid_o;
  logic        mem_rd_ready_i;
  logic [63:0] mem_addr_o;
  logic        mem_rdata_valid_i;
  logic [63:0] mem_rdata_i;
  logic        mem_wr_valid_o;
  logic        mem_wr_ready_i;
  logic [63:0] mem_wdata_o;
  logic        mem_wr_word_o;
  logic        snoop_valid_i;
  logic [63:0] snoop_addr_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [63:0] resp_data_o;
  logic        resp_err_o;

  int total = 0;
  int bad   = 0;

  amo_rmw_unit #(.XLEN(64), .ADDR_W(64), .RSV_LOG2(3)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid_i       (req_valid_i),
    .req_ready_o       (req_ready_o),
    .req_funct5_i      (req_funct5_i),
    .req_is_word_i     (req_is_word_i),
    .req_addr_i        (req_addr_i),
    .req_data_i        (req_data_i),
    .mem_rd_valid_o    (mem_rd_valid_o),
    .mem_rd_ready_i    (mem_rd_ready_i),
    .mem_addr_o        (mem_addr_o),
    .mem_rdata_valid_i (mem_rdata_valid_i),
    .mem_rdata_i       (mem_rdata_i),
    .mem_wr_valid_o    (mem_wr_valid_o),
    .mem_wr_ready_i    (mem_wr_ready_i),
    .mem_wdata_o       (mem_wdata_o),
    .mem_wr_word_o     (mem_wr_word_o),
    .snoop_valid_i     (snoop_valid_i),
    .snoop_addr_i      (snoop_addr_i),
    .resp_valid_o      (resp_valid_o),
    .resp_ready_i      (resp_ready_i),
    .resp_data_o       (resp_data_o),
    .resp_err_o        (resp_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and plays memory/consumer with the given stall counts.
  // exp_lat is the cycle (accept = 0) where resp_valid_o first rises; 0 skips that check.
  task automatic do_op(input string tag, input logic [4:0] f5, input logic w,
                       input logic [63:0] addr, input logic [63:0] rs2, input logic [63:0] memv,
                       input int rd_st, input int wr_st, input int rs_st, input logic snoop_rd,
                       input logic exp_rd, input logic exp_wr, input logic [63:0] exp_wdata,
                       input logic [63:0] exp_resp, input logic exp_err, input int exp_lat);
    logic        saw_rd, saw_wr, saw_resp, done, unstable, rd_pending;
    logic        rd_hold, wr_hold, rs_hold, wr_word_seen, err_seen;
    logic [63:0] wdata_seen, resp_seen;
    int          rd_n, wr_n, rs_n, resp_cyc;
    saw_rd = 0; saw_wr = 0; saw_resp = 0; done = 0; unstable = 0; rd_pending = 0;
    rd_hold = 0; wr_hold = 0; rs_hold = 0; wr_word_seen = 0; err_seen = 0;
    wdata_seen = '0; resp_seen = '0; rd_n = 0; wr_n = 0; rs_n = 0; resp_cyc = 0;

    check({tag, "_ready"}, 64'(req_ready_o), 64'd1);
    req_valid_i = 1; req_funct5_i = f5; req_is_word_i = w; req_addr_i = addr; req_data_i = rs2;
    tick();
    req_valid_i = 0;

    for (int cyc = 1; cyc < 60 && !done; cyc++) begin
      mem_rdata_valid_i = rd_pending;
      mem_rdata_i       = rd_pending ? memv : 64'h0;
      snoop_valid_i     = snoop_rd && rd_pending;
      snoop_addr_i      = addr + 64'd4;
      rd_pending        = 0;
      mem_rd_ready_i = 0; mem_wr_ready_i = 0; resp_ready_i = 0;

      if (rd_hold && !mem_rd_valid_o) unstable = 1;
      rd_hold = 0;
      if (mem_rd_valid_o) begin
        saw_rd = 1;
        if (mem_addr_o !== addr) unstable = 1;
        if (rd_n < rd_st) begin rd_n++; rd_hold = 1; end
        else begin mem_rd_ready_i = 1; rd_pending = 1; end
      end

      if (wr_hold && (!mem_wr_valid_o || mem_wdata_o !== wdata_seen)) unstable = 1;
      wr_hold = 0;
      if (mem_wr_valid_o) begin
        saw_wr = 1; wdata_seen = mem_wdata_o; wr_word_seen = mem_wr_word_o;
        if (mem_addr_o !== addr) unstable = 1;
        if (wr_n < wr_st) begin wr_n++; wr_hold = 1; end
        else mem_wr_ready_i = 1;
      end

      if (rs_hold && (!resp_valid_o || resp_data_o !== resp_seen || resp_err_o !== err_seen)) unstable = 1;
      rs_hold = 0;
      if (resp_valid_o) begin
        if (!saw_resp) resp_cyc = cyc;
        saw_resp = 1; resp_seen = resp_data_o; err_seen = resp_err_o;
        if (rs_n < rs_st) begin rs_n++; rs_hold = 1; end
        else begin resp_ready_i = 1; done = 1; end
      end
      tick();
    end
    mem_rd_ready_i = 0; mem_wr_ready_i = 0; resp_ready_i = 0;
    mem_rdata_valid_i = 0; snoop_valid_i = 0;

    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_err"}, 64'(err_seen), 64'(exp_err));
    check({tag, "_resp"}, resp_seen, exp_resp);
    check({tag, "_rd"}, 64'(saw_rd), 64'(exp_rd));
    check({tag, "_wr"}, 64'(saw_wr), 64'(exp_wr));
    if (exp_wr) begin
      check({tag, "_wdata"}, wdata_seen, exp_wdata);
      check({tag, "_wword"}, 64'(wr_word_seen), 64'(w));
    end
    check({tag, "_stable"}, 64'(unstable), 64'd0);
    if (exp_lat != 0) check({tag, "_lat"}, 64'(resp_cyc), 64'(exp_lat));
    check({tag, "_idle"}, 64'(req_ready_o), 64'd1);
  endtask

  task automatic snoop_pulse(input logic [63:0] a);
    snoop_valid_i = 1; snoop_addr_i = a;
    tick();
    snoop_valid_i = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; req_valid_i = 0; req_funct5_i = '0; req_is_word_i = 0; req_addr_i = '0;
    req_data_i = '0; mem_rd_ready_i = 0; mem_rdata_valid_i = 0; mem_rdata_i = '0;
    mem_wr_ready_i = 0; snoop_valid_i = 0; snoop_addr_i = '0; resp_ready_i = 0;
    tick(); tick();

    check("rst_ready",     64'(req_ready_o),    64'd1);
    check("rst_rd_valid",  64'(mem_rd_valid_o), 64'd0);
    check("rst_wr_valid",  64'(mem_wr_valid_o), 64'd0);
    check("rst_resp_valid",64'(resp_valid_o),   64'd0);
    check("rst_resp_data", resp_data_o,         64'd0);
    check("rst_addr",      mem_addr_o,          64'd0);
    check("rst_wdata",     mem_wdata_o,         64'd0);
    rst_n = 1;
    tick();

    //     tag         f5      w  addr        rs2                    mem                    stalls  snp rd wr wdata                  resp                   err lat
    do_op("add_d",     F_ADD,  0, 64'h100,  64'h5,                 64'h10,                0,0,0,  0,  1, 1, 64'h15,                64'h10,                0,  4);
    do_op("min_w",     F_MIN,  1, 64'h104,  64'h1,                 64'h0000_0000_8000_0000,0,0,0, 0,  1, 1, 64'h0000_0000_8000_0000,64'hFFFF_FFFF_8000_0000,0,  4);
    do_op("add_w_wrap",F_ADD,  1, 64'h108,  64'h2,                 64'h0000_0000_FFFF_FFFF,0,0,0, 0,  1, 1, 64'h1,                 64'hFFFF_FFFF_FFFF_FFFF,0,  4);
    do_op("maxu_w",    F_MAXU, 1, 64'h10C,  64'h7FFF_FFFF,         64'h0000_0000_8000_0000,0,0,0, 0,  1, 1, 64'h0000_0000_8000_0000,64'hFFFF_FFFF_8000_0000,0,  4);
    do_op("max_d",     F_MAX,  0, 64'h110,  64'h5,                 64'h8000_0000_0000_0000,0,0,0, 0,  1, 1, 64'h5,                 64'h8000_0000_0000_0000,0,  4);
    do_op("xor_d",     F_XOR,  0, 64'h118,  64'hFF00,              64'hF0F0,              0,0,0,  0,  1, 1, 64'h0FF0,              64'hF0F0,              0,  4);

    do_op("lr_a",      F_LR,   0, 64'h1000, 64'h0,                 64'h77,                0,0,0,  0,  1, 0, 64'h0,                 64'h77,                0,  3);
    do_op("sc_pass",   F_SC,   0, 64'h1000, 64'hAB,                64'h77,                0,0,0,  0,  1, 1, 64'hAB,                64'h0,                 0,  4);
    do_op("sc_again",  F_SC,   0, 64'h1000, 64'hCD,                64'h77,                0,0,0,  0,  0, 0, 64'h0,                 64'h1,                 0,  1);

    do_op("lr_b",      F_LR,   0, 64'h1000, 64'h0,                 64'h55,                0,0,0,  0,  1, 0, 64'h0,                 64'h55,                0,  3);
    snoop_pulse(64'h1004);
    do_op("sc_snooped",F_SC,   0, 64'h1000, 64'hAB,                64'h55,                0,0,0,  0,  0, 0, 64'h0,                 64'h1,                 0,  1);

    do_op("lr_c",      F_LR,   0, 64'h1200, 64'h0,                 64'h9,                 0,0,0,  0,  1, 0, 64'h0,                 64'h9,                 0,  3);
    snoop_pulse(64'h1208);
    do_op("sc_other",  F_SC,   0, 64'h1200, 64'h5,                 64'h9,                 0,0,0,  0,  1, 1, 64'h5,                 64'h0,                 0,  4);

    do_op("lr_race",   F_LR,   0, 64'h1100, 64'h0,                 64'h3,                 0,0,0,  1,  1, 0, 64'h0,                 64'h3,                 0,  3);
    do_op("sc_race",   F_SC,   0, 64'h1100, 64'h4,                 64'h3,                 0,0,0,  0,  0, 0, 64'h0,                 64'h1,                 0,  1);

    do_op("swap_mis",  F_SWAP, 0, 64'h1004, 64'h1,                 64'h0,                 0,0,0,  0,  0, 0, 64'h0,                 64'h0,                 1,  1);
    do_op("illegal",   5'h1F,  0, 64'h2000, 64'h1,                 64'h0,                 0,0,0,  0,  0, 0, 64'h0,                 64'h0,                 1,  1);
    do_op("or_stall",  F_OR,   0, 64'h3000, 64'hF0,                64'h0F,                3,2,2,  0,  1, 1, 64'hFF,                64'h0F,                0,  0);

    // Reservation set here must not survive the reset below.
    do_op("lr_d",      F_LR,   0, 64'h1000, 64'h0,                 64'h1,                 0,0,0,  0,  1, 0, 64'h0,                 64'h1,                 0,  3);
    req_valid_i = 1; req_funct5_i = F_ADD; req_is_word_i = 0; req_addr_i = 64'h4000; req_data_i = 64'h1;
    tick();
    req_valid_i = 0; mem_rd_ready_i = 1;
    tick();
    mem_rd_ready_i = 0; mem_rdata_valid_i = 1; mem_rdata_i = 64'h1;
    tick();
    mem_rdata_valid_i = 0;
    check("mid_wr_valid", 64'(mem_wr_valid_o), 64'd1);
    rst_n = 0;
    #1;
    check("mid_rst_wr_valid",   64'(mem_wr_valid_o), 64'd0);
    check("mid_rst_rd_valid",   64'(mem_rd_valid_o), 64'd0);
    check("mid_rst_resp_valid", 64'(resp_valid_o),   64'd0);
    tick();
    rst_n = 1;
    tick();
    check("mid_rst_ready", 64'(req_ready_o), 64'd1);
    do_op("sc_after_rst", F_SC, 0, 64'h1000, 64'h7,                64'h1,                 0,0,0,  0,  0, 0, 64'h0,                 64'h1,                 0,  1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
